// File: rtl/snn_pkg.sv
// Shared SNN core definitions: default sizing of the output stage and the
// op_spike_maxer state encoding.
package snn_pkg;

   localparam int N_DEF     = 8;
   localparam int IDX_W_DEF = 3;
   localparam int CW_DEF    = 16;
   localparam int W_DEF     = 24;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_SCAN  = 2'd2,
      S_DONE  = 2'd3
   } maxer_state_t;

endpackage : snn_pkg

// File: rtl/spike_ctr_bank.sv
// Bank of N saturating per-neuron spike counters. A clear has priority over
// increments; counts are exported on one flat bus, neuron i at [i*CW +: CW].
module spike_ctr_bank #(
   parameter int N  = 8,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            inc_en,
   input  logic [N-1:0]    ops,
   output logic [N*CW-1:0] cnt_flat
);

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];

   // NOTE: every variable assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr) begin
            cnt_d[i] = '0;
         end else if (inc_en && ops[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // NOTE: the counter array is reset like any other register because the
   // scan may read it straight out of reset; a pure storage memory would not
   // need this. Sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      cnt_flat = '0;
      for (int i = 0; i < N; i++) cnt_flat[i*CW +: CW] = cnt_q[i];
   end

endmodule : spike_ctr_bank

// File: rtl/op_spike_maxer.sv
// Output-neuron spike counter and arg-max stage: counts gated spikes over one
// image, then scans the counters one per cycle and publishes the winner.
module op_spike_maxer
   import snn_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int CW    = CW_DEF,
   parameter int W     = W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_core_img,
   input  logic [N-1:0]     ops,
   input  logic             TU_incre,
   input  logic             done_core_img,
   output logic [IDX_W-1:0] class_idx,
   output logic [CW-1:0]    max_count,
   output logic             no_spike,
   output logic [W-1:0]     threshold_maxer,
   output logic             valid_maxing,
   output logic             busy
);

   localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

   maxer_state_t     state_q, state_d;
   logic [IDX_W-1:0] scan_k_q, scan_k_d;
   logic [CW-1:0]    best_cnt_q, best_cnt_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic [IDX_W-1:0] class_idx_q, class_idx_d;
   logic [CW-1:0]    max_count_q, max_count_d;
   logic             no_spike_q, no_spike_d;
   logic [W-1:0]     thr_q, thr_d;

   logic [N*CW-1:0]  cnt_flat;
   logic [CW-1:0]    cnt_arr [N];
   logic [CW-1:0]    cand_cnt;
   logic             take;
   logic [CW-1:0]    fin_cnt;
   logic [IDX_W-1:0] fin_idx;
   logic             scan_last;

   spike_ctr_bank #(
      .N  (N),
      .CW (CW)
   ) u_ctr_bank (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_core_img),
      .inc_en   (TU_incre && (state_q == S_COUNT)),
      .ops      (ops),
      .cnt_flat (cnt_flat)
   );

   always_comb begin
      for (int i = 0; i < N; i++) cnt_arr[i] = cnt_flat[i*CW +: CW];
   end

   // Running best including the neuron under scan; k=0 seeds from cnt[0] and
   // the strict compare keeps the lowest index on ties.
   always_comb begin
      cand_cnt  = cnt_arr[scan_k_q];
      take      = (scan_k_q == '0) || (cand_cnt > best_cnt_q);
      fin_cnt   = take ? cand_cnt : best_cnt_q;
      fin_idx   = take ? scan_k_q : best_idx_q;
      scan_last = (state_q == S_SCAN) && (scan_k_q == LAST_K);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a start aborts anything in flight.
   always_comb begin
      state_d = state_q;
      if (start_core_img) begin
         state_d = S_COUNT;
      end else begin
         unique case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_COUNT: if (done_core_img) state_d = S_SCAN;
            S_SCAN:  if (scan_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      valid_maxing = (state_q == S_DONE);
      busy         = (state_q == S_COUNT) || (state_q == S_SCAN);
   end

   always_comb begin
      scan_k_d    = scan_k_q;
      best_cnt_d  = best_cnt_q;
      best_idx_d  = best_idx_q;
      class_idx_d = class_idx_q;
      max_count_d = max_count_q;
      no_spike_d  = no_spike_q;
      thr_d       = thr_q;
      if (start_core_img) begin
         scan_k_d   = '0;
         best_cnt_d = '0;
         best_idx_d = '0;
      end else if (state_q == S_SCAN) begin
         scan_k_d   = scan_k_q + 1'b1;
         best_cnt_d = fin_cnt;
         best_idx_d = fin_idx;
         // Results land on the DONE cycle, together with valid_maxing.
         if (scan_last) begin
            class_idx_d = fin_idx;
            max_count_d = fin_cnt;
            no_spike_d  = (fin_cnt == '0);
            thr_d       = W'(fin_cnt);
         end
      end else if ((state_q == S_COUNT) && done_core_img) begin
         scan_k_d   = '0;
         best_cnt_d = '0;
         best_idx_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_k_q    <= '0;
         best_cnt_q  <= '0;
         best_idx_q  <= '0;
         class_idx_q <= '0;
         max_count_q <= '0;
         no_spike_q  <= 1'b0;
         thr_q       <= '0;
      end else begin
         scan_k_q    <= scan_k_d;
         best_cnt_q  <= best_cnt_d;
         best_idx_q  <= best_idx_d;
         class_idx_q <= class_idx_d;
         max_count_q <= max_count_d;
         no_spike_q  <= no_spike_d;
         thr_q       <= thr_d;
      end
   end

   assign class_idx       = class_idx_q;
   assign max_count       = max_count_q;
   assign no_spike        = no_spike_q;
   assign threshold_maxer = thr_q;

endmodule : op_spike_maxer

// File: tb/tb_op_spike_maxer.sv
// Directed bench for op_spike_maxer: default build plus a CW=4 build sharing
// the same stimulus, checked with immediate assertions.
module tb_op_spike_maxer;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start_core_img = 1'b0;
   logic [N-1:0] ops = '0;
   logic         TU_incre = 1'b0;
   logic         done_core_img = 1'b0;

   logic [2:0]   class_idx,  class_idx4;
   logic [15:0]  max_count;
   logic [3:0]   max_count4;
   logic         no_spike,   no_spike4;
   logic [23:0]  threshold_maxer, threshold_maxer4;
   logic         valid_maxing, valid_maxing4;
   logic         busy, busy4;

   int compared = 0;
   int mismatched = 0;
   int lat;
   int nv;

   always #5 clk = ~clk;

   op_spike_maxer dut (
      .clk             (clk),
      .rst             (rst),
      .start_core_img  (start_core_img),
      .ops             (ops),
      .TU_incre        (TU_incre),
      .done_core_img   (done_core_img),
      .class_idx       (class_idx),
      .max_count       (max_count),
      .no_spike        (no_spike),
      .threshold_maxer (threshold_maxer),
      .valid_maxing    (valid_maxing),
      .busy            (busy)
   );

   op_spike_maxer #(.CW(4)) dut4 (
      .clk             (clk),
      .rst             (rst),
      .start_core_img  (start_core_img),
      .ops             (ops),
      .TU_incre        (TU_incre),
      .done_core_img   (done_core_img),
      .class_idx       (class_idx4),
      .max_count       (max_count4),
      .no_spike        (no_spike4),
      .threshold_maxer (threshold_maxer4),
      .valid_maxing    (valid_maxing4),
      .busy            (busy4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_img();
      start_core_img = 1'b1;
      tick();
      start_core_img = 1'b0;
   endtask

   task automatic tus(input logic [N-1:0] pattern, input int n);
      ops = pattern;
      TU_incre = 1'b1;
      repeat (n) tick();
      TU_incre = 1'b0;
      ops = '0;
   endtask

   // Pulse done (optionally with a final TU) and watch for valid_maxing over a
   // bounded window; lat is the cycle index after the done cycle, 0 if never.
   task automatic run_scan(input logic tu_too, input logic [N-1:0] pattern,
                           output int lat_o, output int nv_o);
      lat_o = 0;
      nv_o  = 0;
      done_core_img = 1'b1;
      TU_incre = tu_too;
      ops = pattern;
      tick();
      done_core_img = 1'b0;
      TU_incre = 1'b0;
      ops = '0;
      for (int c = 1; c <= N + 5; c++) begin
         if (valid_maxing) begin
            nv_o++;
            lat_o = c;
         end
         tick();
      end
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("rst_class", 32'(class_idx), 0);
      check("rst_max", 32'(max_count), 0);
      check("rst_thr", 32'(threshold_maxer), 0);
      check("rst_valid", 32'(valid_maxing), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_nospike", 32'(no_spike), 0);

      // 1: neuron 2 spikes 10 times
      start_img();
      check("t1_busy_count", 32'(busy), 1);
      tus(8'b0000_0100, 10);
      run_scan(1'b0, '0, lat, nv);
      check("t1_latency", lat, N + 1);
      check("t1_pulses", nv, 1);
      check("t1_class", 32'(class_idx), 2);
      check("t1_max", 32'(max_count), 10);
      check("t1_thr", 32'(threshold_maxer), 10);
      check("t1_nospike", 32'(no_spike), 0);
      check("t1_busy_idle", 32'(busy), 0);

      // 2: tie between neurons 1 and 5, lower index wins
      start_img();
      tus(8'b0010_0010, 7);
      tus(8'b1000_0000, 3);
      run_scan(1'b0, '0, lat, nv);
      check("t2_class", 32'(class_idx), 1);
      check("t2_max", 32'(max_count), 7);
      check("t2_pulses", nv, 1);

      // Winner at the last index
      start_img();
      tus(8'b1000_0000, 12);
      tus(8'b0000_0001, 5);
      run_scan(1'b0, '0, lat, nv);
      check("last_class", 32'(class_idx), 7);
      check("last_max", 32'(max_count), 12);

      // 3: no spikes; ops without TU_incre are ignored
      start_img();
      tus(8'b0000_0000, 20);
      ops = 8'hFF;
      repeat (3) tick();
      ops = '0;
      run_scan(1'b0, '0, lat, nv);
      check("t3_class", 32'(class_idx), 0);
      check("t3_max", 32'(max_count), 0);
      check("t3_nospike", 32'(no_spike), 1);
      check("t3_thr", 32'(threshold_maxer), 0);
      check("t3_pulses", nv, 1);

      // 4: saturation, CW=4 build holds 15, default build counts 20
      start_img();
      tus(8'b0000_1000, 20);
      run_scan(1'b0, '0, lat, nv);
      check("t4_max_cw4", 32'(max_count4), 15);
      check("t4_class_cw4", 32'(class_idx4), 3);
      check("t4_thr_cw4", 32'(threshold_maxer4), 15);
      check("t4_max_cw16", 32'(max_count), 20);

      // 5: TU counted in the same cycle as done
      start_img();
      tus(8'b0100_0000, 4);
      run_scan(1'b1, 8'b0100_0000, lat, nv);
      check("t5_max", 32'(max_count), 5);
      check("t5_class", 32'(class_idx), 6);
      check("t5_latency", lat, N + 1);

      // done while IDLE is ignored
      done_core_img = 1'b1;
      tick();
      done_core_img = 1'b0;
      check("idle_done_busy", 32'(busy), 0);

      // 6: start on SCAN cycle 3 aborts the scan
      start_img();
      tus(8'b0000_0001, 3);
      done_core_img = 1'b1;
      tick();
      done_core_img = 1'b0;
      tick();
      tick();
      start_img();
      check("t6_busy", 32'(busy), 1);
      check("t6_held_class", 32'(class_idx), 6);
      check("t6_held_max", 32'(max_count), 5);
      nv = 0;
      for (int c = 0; c < N + 4; c++) begin
         if (valid_maxing) nv++;
         tick();
      end
      check("t6_no_valid", nv, 0);
      run_scan(1'b0, '0, lat, nv);
      check("t6_cleared_max", 32'(max_count), 0);
      check("t6_cleared_nospike", 32'(no_spike), 1);
      check("t6_cleared_class", 32'(class_idx), 0);

      // Async reset mid-COUNT
      start_img();
      tus(8'b0000_0100, 5);
      #3 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_class", 32'(class_idx), 0);
      check("arst_max", 32'(max_count), 0);
      check("arst_nospike", 32'(no_spike), 0);
      check("arst_thr", 32'(threshold_maxer), 0);
      check("arst_valid", 32'(valid_maxing), 0);
      tick();
      rst = 1'b0;
      tick();
      run_scan(1'b0, '0, lat, nv);
      check("arst_idle_no_valid", nv, 0);
      check("arst_idle_busy", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_op_spike_maxer
